// File: rtl/game_pkg.sv
// Shared types and helpers for the brick-breaker game-state controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SERVE       = 3'd1,
        PLAY        = 3'd2,
        PAUSE       = 3'd3,
        LIFE_LOST   = 3'd4,
        LEVEL_CLEAR = 3'd5,
        LOSE        = 3'd6,
        WIN         = 3'd7
    } game_state_e;

    // Widest brick vector the popcount helper accepts; narrower vectors are zero-extended.
    localparam int POP_MAX_W = 256;
    localparam int POP_CNT_W = 9;

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v,
                                                      input int unsigned          w);
        logic [POP_CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            if ((i < int'(w)) && v[i]) begin
                c = c + POP_CNT_W'(1);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/game_fsm_if.sv
// Signal bundle between the game controller and the ball/paddle/brick/draw blocks.
interface game_fsm_if #(
    parameter int NUM_BRICKS = 6,
    parameter int NUM_LIVES  = 3,
    parameter int NUM_LEVELS = 4,
    parameter int SCORE_W    = 16
);
    localparam int LIVES_W = $clog2(NUM_LIVES + 1);
    localparam int LEVEL_W = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1;

    logic                  start;
    logic                  pause;
    logic [NUM_BRICKS-1:0] bricks_exist;
    logic [NUM_BRICKS-1:0] bricks_death_zone;
    logic                  ball_lost;

    logic                  run;
    logic                  launch;
    logic                  bricks_reload;
    logic [LIVES_W-1:0]    lives;
    logic [LEVEL_W-1:0]    level;
    logic [SCORE_W-1:0]    score;
    logic                  game_over;
    logic                  victory;
    logic [2:0]            state;

    // master: the game world (buttons, bricks, ball); slave: the controller.
    modport master (
        output start, pause, bricks_exist, bricks_death_zone, ball_lost,
        input  run, launch, bricks_reload, lives, level, score, game_over, victory, state
    );

    modport slave (
        input  start, pause, bricks_exist, bricks_death_zone, ball_lost,
        output run, launch, bricks_reload, lives, level, score, game_over, victory, state
    );

endinterface

// File: rtl/game_fsm_button_press.sv
// Falling-edge detector for an active-low button: one pulse per press, however long it is held.
module button_press (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_n;
        end
    end

    assign press = btn_q & ~btn_n;

endmodule

// File: rtl/game_fsm.sv
// Game-state controller: serve timing, lives, levels, scoring, pause and restart.
module game_fsm
    import game_pkg::*;
#(
    parameter int NUM_BRICKS      = 6,
    parameter int NUM_LIVES       = 3,
    parameter int NUM_LEVELS      = 4,
    parameter int SCORE_W         = 16,
    parameter int SCORE_PER_BRICK = 10,
    parameter int SERVE_DELAY     = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    game_fsm_if.slave   bus
);

    localparam int LIVES_W = $clog2(NUM_LIVES + 1);
    localparam int LEVEL_W = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1;
    localparam int CNT_W   = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam int SUM_W   = SCORE_W + 32;

    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_DELAY - 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(NUM_LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    game_state_e state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LIVES_W-1:0]    lives_q, lives_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [NUM_BRICKS-1:0] exist_q;

    logic run_q, launch_q, reload_q, over_q, vic_q;
    logic run_d, launch_d, reload_d, over_d, vic_d;

    logic start_press, pause_press;
    logic new_game, next_level;

    logic [NUM_BRICKS-1:0] removed;
    logic [POP_CNT_W-1:0]  removed_cnt;
    logic [SUM_W-1:0]      add_pts, sum_full;
    logic [SCORE_W-1:0]    score_sat;

    button_press u_start_press (
        .clk   (clk),
        .rst   (rst),
        .btn_n (bus.start),
        .press (start_press)
    );

    button_press u_pause_press (
        .clk   (clk),
        .rst   (rst),
        .btn_n (bus.pause),
        .press (pause_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lives_q  <= FULL_LIVES;
            level_q  <= '0;
            score_q  <= '0;
            exist_q  <= '1;
            run_q    <= 1'b0;
            launch_q <= 1'b0;
            reload_q <= 1'b0;
            over_q   <= 1'b0;
            vic_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            score_q  <= score_d;
            exist_q  <= bus.bricks_exist;
            run_q    <= run_d;
            launch_q <= launch_d;
            reload_q <= reload_d;
            over_q   <= over_d;
            vic_q    <= vic_d;
        end
    end

    // Next state; PLAY exits are prioritised death zone > ball lost > level clear > pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_press) state_d = SERVE;
            end
            SERVE: begin
                if (cnt_q == SERVE_LAST) state_d = PLAY;
            end
            PLAY: begin
                if (|bus.bricks_death_zone)  state_d = LOSE;
                else if (bus.ball_lost)      state_d = LIFE_LOST;
                else if (~|bus.bricks_exist) state_d = LEVEL_CLEAR;
                else if (pause_press)        state_d = PAUSE;
            end
            PAUSE: begin
                if (pause_press) state_d = PLAY;
            end
            LIFE_LOST: begin
                state_d = (lives_q <= LIVES_W'(1)) ? LOSE : SERVE;
            end
            LEVEL_CLEAR: begin
                state_d = (level_q == LAST_LEVEL) ? WIN : SERVE;
            end
            LOSE, WIN: begin
                if (start_press) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Score only counts bricks that vanished since last cycle; reappearing bricks are ignored.
    always_comb begin
        removed     = exist_q & ~bus.bricks_exist;
        removed_cnt = popcount(POP_MAX_W'(removed), NUM_BRICKS);
        add_pts     = SUM_W'(SCORE_PER_BRICK) * SUM_W'(removed_cnt);
        sum_full    = SUM_W'(score_q) + add_pts;
        score_sat   = (sum_full > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum_full[SCORE_W-1:0];
    end

    always_comb begin
        new_game   = (state_q == IDLE) && start_press;
        next_level = (state_q == LEVEL_CLEAR) && (state_d == SERVE);

        cnt_d = '0;
        if ((state_q == SERVE) && (state_d == SERVE)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        lives_d = lives_q;
        if (new_game) begin
            lives_d = FULL_LIVES;
        end else if ((state_q == LIFE_LOST) && (lives_q != '0)) begin
            lives_d = lives_q - LIVES_W'(1);
        end

        level_d = level_q;
        if (new_game) begin
            level_d = '0;
        end else if (next_level) begin
            level_d = level_q + LEVEL_W'(1);
        end

        score_d = score_q;
        if (new_game) begin
            score_d = '0;
        end else if (state_q == PLAY) begin
            score_d = score_sat;
        end
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        run_d    = (state_d == PLAY);
        over_d   = (state_d == LOSE);
        vic_d    = (state_d == WIN);
        reload_d = new_game || next_level;
        launch_d = (state_d == SERVE) && (cnt_d == SERVE_LAST);
    end

    assign bus.run           = run_q;
    assign bus.launch        = launch_q;
    assign bus.bricks_reload = reload_q;
    assign bus.lives         = lives_q;
    assign bus.level         = level_q;
    assign bus.score         = score_q;
    assign bus.game_over     = over_q;
    assign bus.victory       = vic_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: randomized play against a rule-level game model.
module tb_game_fsm;

  localparam int NB  = 6;
  localparam int NL  = 3;
  localparam int NLV = 2;
  localparam int SW  = 16;
  localparam int SPB = 10;
  localparam int SD  = 8;
  localparam int SCORE_CAP = (1 << SW) - 1;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3;
  localparam int S_LIFE_LOST = 4, S_LEVEL_CLEAR = 5, S_LOSE = 6, S_WIN = 7;

  logic clk = 1'b0;
  logic rst;

  game_fsm_if #(.NUM_BRICKS(NB), .NUM_LIVES(NL), .NUM_LEVELS(NLV), .SCORE_W(SW)) bus ();

  game_fsm #(
    .NUM_BRICKS(NB), .NUM_LIVES(NL), .NUM_LEVELS(NLV), .SCORE_W(SW),
    .SCORE_PER_BRICK(SPB), .SERVE_DELAY(SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];   // expected launch cycles

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_state, m_lives, m_level, m_score, m_serve_left;
  bit          m_reload, m_start_q, m_pause_q;
  logic [NB-1:0] m_exist;
  int unsigned cyc = 0;

  task automatic model_reset();
    m_state = S_IDLE; m_lives = NL; m_level = 0; m_score = 0;
    m_serve_left = 0; m_reload = 0; m_start_q = 1; m_pause_q = 1;
    m_exist = '1;
    exp_q.delete();
  endtask

  task automatic enter_serve();
    m_serve_left = SD;
    exp_q.push_back(cyc + SD - 1);
  endtask

  task automatic model_step();
    bit sp, pp;
    int removed, nxt;
    sp = m_start_q && !bus.start;
    pp = m_pause_q && !bus.pause;
    m_start_q = bus.start;
    m_pause_q = bus.pause;
    removed = $countones(m_exist & ~bus.bricks_exist);
    m_exist = bus.bricks_exist;
    m_reload = 0;
    nxt = m_state;
    case (m_state)
      S_IDLE: if (sp) begin
        nxt = S_SERVE; m_reload = 1; m_lives = NL; m_level = 0; m_score = 0; enter_serve();
      end
      S_SERVE: if (m_serve_left == 1) nxt = S_PLAY; else m_serve_left--;
      S_PLAY: begin
        m_score = m_score + SPB * removed;
        if (m_score > SCORE_CAP) m_score = SCORE_CAP;
        if (bus.bricks_death_zone != 0) nxt = S_LOSE;
        else if (bus.ball_lost)         nxt = S_LIFE_LOST;
        else if (bus.bricks_exist == 0) nxt = S_LEVEL_CLEAR;
        else if (pp)                    nxt = S_PAUSE;
      end
      S_PAUSE: if (pp) nxt = S_PLAY;
      S_LIFE_LOST: begin
        m_lives--;
        if (m_lives == 0) nxt = S_LOSE;
        else begin nxt = S_SERVE; enter_serve(); end
      end
      S_LEVEL_CLEAR: begin
        if (m_level == NLV - 1) nxt = S_WIN;
        else begin m_level++; m_reload = 1; nxt = S_SERVE; enter_serve(); end
      end
      default: if (sp) nxt = S_IDLE;
    endcase
    m_state = nxt;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      cyc++;
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("state",         bus.state,         m_state);
    chk("run",           bus.run,           m_state == S_PLAY);
    chk("launch",        bus.launch,        (m_state == S_SERVE) && (m_serve_left == 1));
    chk("bricks_reload", bus.bricks_reload, m_reload);
    chk("lives",         bus.lives,         m_lives);
    chk("level",         bus.level,         m_level);
    chk("score",         bus.score,         m_score);
    chk("game_over",     bus.game_over,     m_state == S_LOSE);
    chk("victory",       bus.victory,       m_state == S_WIN);
    if (rst && bus.launch) begin
      if (exp_q.size() == 0) chk("launch_unexpected", 1, 0);
      else chk("launch_cycle", cyc, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start(input int hold);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (hold) tick();
    bus.start = 1'b1;
  endtask

  task automatic press_pause(input int hold);
    bus.pause = 1'b1;
    tick();
    bus.pause = 1'b0;
    repeat (hold) tick();
  endtask

  task automatic wait_state(input int s, input string name);
    int n = 0;
    while (m_state != s && n < 60) begin
      tick();
      n++;
    end
    chk(name, bus.state, s);
  endtask

  task automatic clear_all_bricks();
    logic [NB-1:0] cur;
    cur = '1;
    for (int k = 0; k < 30 && cur != 0; k++) begin
      cur = (k == 29) ? '0 : (cur & NB'($urandom_range(0, 63)));
      bus.bricks_exist = cur;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    bus.start = 1'b1;
    bus.pause = 1'b1;
    bus.bricks_exist = '1;
    bus.bricks_death_zone = '0;
    bus.ball_lost = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bus.state, S_IDLE);
    chk("rst_lives", bus.lives, 3);
    chk("rst_score", bus.score, 0);
    chk("rst_run", bus.run, 0);
    rst = 1'b1;
    tick();

    // 1: serve timing
    press_start(1);
    chk("t1_reload", bus.bricks_reload, 1);
    chk("t1_lives", bus.lives, 3);
    repeat (6) tick();
    chk("t7_launch", bus.launch, 0);
    tick();
    chk("t8_launch", bus.launch, 1);
    chk("t8_run", bus.run, 0);
    tick();
    chk("t9_run", bus.run, 1);
    chk("t9_launch", bus.launch, 0);

    // 2: scoring
    bus.bricks_exist = 6'b110110; tick();
    chk("score_two", bus.score, 20);
    bus.bricks_exist = 6'b010110; tick();
    chk("score_one", bus.score, 30);
    bus.bricks_exist = 6'b010111; tick();
    chk("score_reappear", bus.score, 30);
    repeat (12) begin
      bus.bricks_exist = NB'($urandom_range(1, 63));
      tick();
    end

    // 3: losing all lives
    for (int i = 0; i < 3; i++) begin
      bus.ball_lost = 1'b1; tick(); bus.ball_lost = 1'b0;
      chk("life_lost_state", bus.state, S_LIFE_LOST);
      tick();
      if (i < 2) begin
        chk("reserve_state", bus.state, S_SERVE);
        chk("lives_left", bus.lives, 2 - i);
        wait_state(S_PLAY, "wait_play_life");
      end
    end
    chk("lose_state", bus.state, S_LOSE);
    chk("lose_game_over", bus.game_over, 1);
    chk("lose_run", bus.run, 0);
    chk("lose_lives", bus.lives, 0);
    press_start(3);
    chk("restart_idle", bus.state, S_IDLE);
    chk("idle_lives_held", bus.lives, 0);
    bus.bricks_exist = '1;
    press_start(1);
    chk("new_game_lives", bus.lives, 3);
    chk("new_game_score", bus.score, 0);

    // 4: level progression and victory
    wait_state(S_PLAY, "wait_play_l0");
    clear_all_bricks();
    chk("level_clear_state", bus.state, S_LEVEL_CLEAR);
    bus.bricks_exist = '1;
    tick();
    chk("level1_state", bus.state, S_SERVE);
    chk("level1_level", bus.level, 1);
    chk("level1_reload", bus.bricks_reload, 1);
    chk("level1_score", bus.score, 60);
    wait_state(S_PLAY, "wait_play_l1");
    clear_all_bricks();
    chk("level_clear2_state", bus.state, S_LEVEL_CLEAR);
    tick();
    chk("win_state", bus.state, S_WIN);
    chk("win_victory", bus.victory, 1);
    chk("win_score", bus.score, 120);

    // 5: simultaneous events
    bus.bricks_exist = '1;
    press_start(2);
    chk("win_idle_level_held", bus.level, 1);
    press_start(1);
    chk("new_level", bus.level, 0);
    wait_state(S_PLAY, "wait_play_sim");
    bus.bricks_exist = 6'b000001; tick();
    chk("sim_score_pre", bus.score, 50);
    bus.ball_lost = 1'b1; bus.bricks_death_zone = 6'b100000; bus.bricks_exist = '0;
    tick();
    bus.ball_lost = 1'b0; bus.bricks_death_zone = '0; bus.bricks_exist = '1;
    chk("sim_state", bus.state, S_LOSE);
    chk("sim_lives", bus.lives, 3);
    chk("sim_score", bus.score, 60);

    // 6: pause, then async reset during serve
    press_start(1);
    press_start(1);
    wait_state(S_PLAY, "wait_play_pause");
    bus.bricks_exist = 6'b111110; tick();
    chk("pause_score_pre", bus.score, 10);
    press_pause($urandom_range(1, 3));
    chk("pause_state", bus.state, S_PAUSE);
    chk("pause_run", bus.run, 0);
    repeat (10) begin
      bus.bricks_exist = NB'($urandom_range(0, 63));
      bus.ball_lost = 1'($urandom_range(0, 1));
      bus.bricks_death_zone = NB'($urandom_range(0, 63));
      tick();
    end
    chk("pause_score_held", bus.score, 10);
    chk("pause_state_held", bus.state, S_PAUSE);
    bus.ball_lost = 1'b0; bus.bricks_death_zone = '0; bus.bricks_exist = '1;
    press_pause(1);
    bus.pause = 1'b1;
    chk("resume_state", bus.state, S_PLAY);
    chk("resume_launch", bus.launch, 0);
    tick();
    chk("resume_score", bus.score, 10);
    bus.bricks_death_zone = 6'b000100; tick(); bus.bricks_death_zone = '0;
    chk("dz_lose", bus.state, S_LOSE);
    press_start(1);
    press_start(1);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state", bus.state, S_IDLE);
    chk("async_rst_reload", bus.bricks_reload, 0);
    chk("async_rst_lives", bus.lives, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    press_start(1);
    repeat (7) tick();
    chk("post_rst_launch", bus.launch, 1);
    tick();
    chk("post_rst_run", bus.run, 1);
    repeat (3) tick();
    chk("launch_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
# game_fsm

Parametrised game-state controller for the brick-breaker top level. It replaces the fixed six-brick START/PLAY/CHECK_STATUS/LOSE/WIN sequencer. It adds N bricks, multiple lives, multi-level progression, scoring, pause and restart. The ball, paddle, brick and draw blocks consume its `run`, `launch`, `bricks_reload`, score, lives and level outputs.

## Interface
- `NUM_BRICKS`, 6: width of the brick status vectors.
- `NUM_LIVES`, 3: lives loaded at game start; minimum 1.
- `NUM_LEVELS`, 4: levels to clear for victory; minimum 1.
- `SCORE_W`, 16: score width.
- `SCORE_PER_BRICK`, 10: points added per destroyed brick.
- `SERVE_DELAY`, 50000000: cycles spent in SERVE before launch; minimum 1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  active-low start button, synchronous to `clk`.
- `pause`  in  1  active-low pause button, synchronous to `clk`.
- `bricks_exist`  in  NUM_BRICKS  per-brick alive flags.
- `bricks_death_zone`  in  NUM_BRICKS  per-brick "reached paddle row" flags.
- `ball_lost`  in  1  ball passed the paddle; level-sensitive.
- `run`  out  1  high only in PLAY; gates ball and brick movement.
- `launch`  out  1  one-cycle pulse that re-serves the ball.
- `bricks_reload`  out  1  one-cycle pulse that re-creates all bricks.
- `lives`  out  $clog2(NUM_LIVES+1)  remaining lives.
- `level`  out  max(1,$clog2(NUM_LEVELS))  current level, 0-based.
- `score`  out  SCORE_W  accumulated score.
- `game_over`  out  1  high in LOSE.
- `victory`  out  1  high in WIN.
- `state`  out  3  current state encoding (debug/draw).

## Operation
- **Press detection:** a press is `start` (or `pause`) low this cycle while its registered copy was high. Holding a button gives one press.
- **IDLE:** a start press enters SERVE, pulses `bricks_reload`, and loads lives=NUM_LIVES, level=0, score=0.
- **SERVE:** a counter runs from 0 to SERVE_DELAY-1. On the final count, pulse `launch` and enter PLAY.
- **PLAY:** priority per cycle is, highest first:
  1. Any `bricks_death_zone` bit set: go to LOSE.
  2. `ball_lost`: go to LIFE_LOST.
  3. `bricks_exist`==0: go to LEVEL_CLEAR.
  4. Pause press: go to PAUSE.
- **Scoring in PLAY:** every cycle, score += SCORE_PER_BRICK × popcount(exist_q & ~bricks_exist). `exist_q` is the previous-cycle `bricks_exist`, sampled every cycle in all states. Score saturates at 2^SCORE_W−1. It is updated even on the cycle a transition is taken.
- **PAUSE:** `run`=0 and all counters hold. A pause press returns to PLAY; no `launch` is issued.
- **LIFE_LOST:** one cycle. If lives==1: lives=0, go to LOSE. Otherwise lives−1, go to SERVE.
- **LEVEL_CLEAR:** one cycle.
  - If level==NUM_LEVELS−1: go to WIN.
  - Otherwise: level+1, pulse `bricks_reload`, go to SERVE.
- **LOSE / WIN:** `game_over` / `victory` held high. A start press goes to IDLE; score, lives and level are held until the next IDLE start.
- `ball_lost` and `bricks_death_zone` are ignored outside PLAY.

## Timing
- Reset values:
  - state=IDLE, `run`=0, `launch`=0, `bricks_reload`=0.
  - lives=NUM_LIVES, level=0, score=0.
  - `game_over`=0, `victory`=0.
  - `exist_q`=all ones; button registers=1.
- All outputs are registered. `game_over`/`victory`/`run` change in the same cycle the state changes.
- Start press at cycle t in IDLE: SERVE at t+1, `bricks_reload` high at t+1. `launch` high at t+SERVE_DELAY, which is also the last SERVE cycle. PLAY and `run`=1 at t+SERVE_DELAY+1.
- `ball_lost` in PLAY at cycle t: LIFE_LOST at t+1, SERVE at t+2.
- Reset mid-operation forces reset values immediately (asynchronous), including clearing the SERVE counter.

## Structure
- The `game_pkg` package holds:
  - the state enum: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LIFE_LOST=4, LEVEL_CLEAR=5, LOSE=6, WIN=7;
  - a popcount function parametrised on width.
- Sub-module `button_press` (clk, rst, btn_n → press pulse) is instantiated twice, for `start` and `pause`.

## Test plan
Bench parameters: SERVE_DELAY=8, NUM_LIVES=3, NUM_LEVELS=2, SCORE_PER_BRICK=10.
1. Reset, then a start press at cycle t → `bricks_reload` at t+1, `launch` at t+8, `run`=1 from t+9; lives=3, score=0.
2. In PLAY, clear bricks 0 and 3 in one cycle, then brick 5 → score 20, then 30. A brick re-appearing does not decrement the score.
3. Drive `ball_lost` three times, each after re-entering PLAY → lives 2, 1, 0. After the third: LOSE, `game_over`=1, `run`=0. A start press → IDLE; the next start press reloads lives=3.
4. Clear all 6 bricks on level 0 → LEVEL_CLEAR, level=1, `bricks_reload` pulse, SERVE. Clear all again → WIN, `victory`=1.
5. In the same cycle, assert `ball_lost`, a death-zone bit, and final brick cleared → LOSE directly; lives unchanged; score includes the cleared brick.
6. Pause press in PLAY → `run`=0; inputs are ignored and score holds. A second press → PLAY with no `launch`. Async reset in SERVE mid-count → IDLE at once.
